// File: rtl/dff_bank_arbiter.sv
// dff_bank_arbiter
//
// Purpose:
//    Shares one WIDTH-bit register bank (q / q_bar) between N_REQ requesters.
//    A round-robin arbiter picks one requester per arbitration cycle. That
//    requester's data is staged, and one cycle later it is committed to the
//    bank together with a one-cycle grant pulse. A multi-cycle clear sequence
//    zeroes the bank and takes priority over loads.
//
// Ports:
//    clk        in   rising-edge clock
//    reset      in   asynchronous active-high reset
//    req        in   [N_REQ]        per-requester load request (level)
//    data_in    in   [N_REQ*WIDTH]  requester i data at [i*WIDTH +: WIDTH]
//    clr_req    in   clear request (level)
//    grant      out  [N_REQ]  one-hot pulse on commit of that requester's data
//    q          out  [WIDTH]  bank contents
//    q_bar      out  [WIDTH]  bitwise inverse of q
//    busy       out  high while in LOAD or CLEAR
//    clr_done   out  one-cycle pulse when the clear sequence ends
//    load_count out  [16] saturating commit counter (only with DFF_ARB_STATS_EN)
//
// Optional feature macro: DFF_ARB_STATS_EN adds the load_count output.

module dff_bank_arbiter #(
    parameter int N_REQ      = 4,
    parameter int WIDTH      = 8,
    parameter int CLR_CYCLES = 10
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [N_REQ-1:0]       req,
    input  logic [N_REQ*WIDTH-1:0] data_in,
    input  logic                   clr_req,
    output logic [N_REQ-1:0]       grant,
    output logic [WIDTH-1:0]       q,
    output logic [WIDTH-1:0]       q_bar,
    output logic                   busy,
    output logic                   clr_done
`ifdef DFF_ARB_STATS_EN
    ,
    output logic [15:0]            load_count
`endif
);

    localparam int IDXW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int CNTW = $clog2(CLR_CYCLES + 1);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        CLEAR
    } state_t;

    state_t            state_q, state_d;
    logic [IDXW-1:0]   ptr_q, ptr_d;
    logic [IDXW-1:0]   win_q, win_d;
    logic [WIDTH-1:0]  stage_q, stage_d;
    logic [CNTW-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]  bank_q, bank_d;
    logic [N_REQ-1:0]  grant_q, grant_d;
    logic              clrDone_q, clrDone_d;
    logic              busy_q, busy_d;

    logic [N_REQ-1:0]  eligible;
    logic              winFound;
    logic [IDXW-1:0]   winIdx;
    logic [IDXW-1:0]   scanIdx;
    logic [WIDTH-1:0]  winData;

    // Round-robin pick: scan upward from the pointer, wrapping at N_REQ-1.
    // The requester being granted this cycle is masked out because it only
    // drops its req after seeing its grant bit.
    always_comb begin
        eligible = req & ~grant_q;
        winFound = 1'b0;
        winIdx   = '0;
        scanIdx  = '0;
        for (int k = 0; k < N_REQ; k++) begin
            scanIdx = IDXW'((int'(ptr_q) + k) % N_REQ);
            if (!winFound && eligible[scanIdx]) begin
                winFound = 1'b1;
                winIdx   = scanIdx;
            end
        end
    end

    // Select the winner's data slice with constant part-selects.
    always_comb begin
        winData = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (winIdx == IDXW'(i)) begin
                winData = data_in[i*WIDTH +: WIDTH];
            end
        end
    end

    // Next-state logic. Clear wins over any request in IDLE. LOAD always
    // commits the staged data after exactly one cycle. CLEAR counts down
    // from CLR_CYCLES-1 and returns to IDLE with a clr_done pulse.
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        win_d     = win_q;
        stage_d   = stage_q;
        cnt_d     = cnt_q;
        bank_d    = bank_q;
        grant_d   = '0;
        clrDone_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (clr_req) begin
                    state_d = CLEAR;
                    bank_d  = '0;
                    cnt_d   = CNTW'(CLR_CYCLES - 1);
                end else if (winFound) begin
                    state_d = LOAD;
                    win_d   = winIdx;
                    stage_d = winData;
                end
            end
            LOAD: begin
                state_d = IDLE;
                bank_d  = stage_q;
                for (int i = 0; i < N_REQ; i++) begin
                    grant_d[i] = (win_q == IDXW'(i));
                end
                ptr_d = (win_q == IDXW'(N_REQ - 1)) ? '0 : win_q + IDXW'(1);
            end
            CLEAR: begin
                bank_d = '0;
                if (cnt_q == '0) begin
                    state_d   = IDLE;
                    clrDone_d = 1'b1;
                end else begin
                    cnt_d = cnt_q - CNTW'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        busy_d = (state_d != IDLE);
    end

    // State and datapath registers. Reset discards any staged load.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            ptr_q     <= '0;
            win_q     <= '0;
            stage_q   <= '0;
            cnt_q     <= '0;
            bank_q    <= '0;
            grant_q   <= '0;
            clrDone_q <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            win_q     <= win_d;
            stage_q   <= stage_d;
            cnt_q     <= cnt_d;
            bank_q    <= bank_d;
            grant_q   <= grant_d;
            clrDone_q <= clrDone_d;
            busy_q    <= busy_d;
        end
    end

    assign q        = bank_q;
    assign q_bar    = ~bank_q;
    assign grant    = grant_q;
    assign busy     = busy_q;
    assign clr_done = clrDone_q;

`ifdef DFF_ARB_STATS_EN
    logic [15:0] loadCount_q, loadCount_d;

    // Commit counter: counts every LOAD commit, sticks at all ones and is
    // untouched by the clear sequence.
    always_comb begin
        loadCount_d = loadCount_q;
        if (state_q == LOAD && loadCount_q != 16'hFFFF) begin
            loadCount_d = loadCount_q + 16'd1;
        end
    end

    // Counter register, cleared only by reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            loadCount_q <= '0;
        end else begin
            loadCount_q <= loadCount_d;
        end
    end

    assign load_count = loadCount_q;
`endif

endmodule
